hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the combinational ALU in the execute stage and receives the same two register operands. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the results in HI/LO for MFHI/MFLO. It also performs MTHI/MTLO writes, and asserts `busy` so the control unit stalls the pipeline.

---
 rtl/hilo_muldiv.sv | 151 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; both take 32 iterations plus a sign-fix cycle.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] acc;      // product high half, or partial remainder
    logic [31:0] shreg;    // multiplier shifting out / dividend shifting out, quotient shifting in
    logic [31:0] opb;      // multiplicand or divisor magnitude
    logic        neg_p;    // negate product, or quotient
    logic        neg_r;    // negate remainder
    logic        is_div;
    logic        b_zero;

    logic        sgn_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        sgn_op    = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = mag32(a, sgn_op);
        b_mag     = mag32(b, sgn_op);
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : 33'd0);
        div_shift = {acc, shreg[31]};
        div_trial = div_shift - {1'b0, opb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            acc      <= 32'd0;
            shreg    <= 32'd0;
            opb      <= 32'd0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc    <= 32'd0;
                                shreg  <= a_mag;
                                opb    <= b_mag;
                                neg_p  <= sgn_op & (a[31] ^ b[31]);
                                neg_r  <= sgn_op & a[31];
                                is_div <= op[1];
                                b_zero <= (b == 32'd0);
                                cnt    <= 5'd0;
                                busy   <= 1'b1;
                                state  <= op[1] ? S_DIV : S_MUL;
                            end
                            OP_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc   <= mul_sum[32:1];
                    shreg <= {mul_sum[0], shreg[31:1]};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
                S_DIV: begin
                    // Keep the trial difference only when it did not borrow.
                    if (!div_trial[32]) begin
                        acc   <= div_trial[31:0];
                        shreg <= {shreg[30:0], 1'b1};
                    end else begin
                        acc   <= div_shift[31:0];
                        shreg <= {shreg[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
                default: begin
                    if (is_div) begin
                        if (b_zero) begin
                            div_zero <= 1'b1;
                        end else begin
                            lo <= neg32(shreg, neg_p);
                            hi <= neg32(acc, neg_r);
                        end
                    end else begin
                        {hi, lo} <= neg64({acc, shreg}, neg_p);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic HI/LO reference model.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    hilo_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic on the architectural operands.
    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic exp_dz);
        longint      sx, sy, q, r;
        logic [63:0] p;
        exp_dz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd2: begin
                if (y == 0) exp_dz = 1'b1;
                else begin
                    q = sx / sy; r = sx % sy;
                    model_lo = 32'(q); model_hi = 32'(r);
                end
            end
            3'd3: begin
                if (y == 0) exp_dz = 1'b1;
                else begin model_lo = x / y; model_hi = x % y; end
            end
            3'd4: model_hi = x;
            3'd5: model_lo = x;
            default: ;
        endcase
    endtask

    // Issues one request from just after a clock edge and follows it to completion.
    // Returns right after the edge where done rose, so a following call starts back-to-back.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic exp_dz;
        int   n, busy_cnt;
        logic [31:0] old_hi, old_lo;
        old_hi = model_hi;
        old_lo = model_lo;
        model_op(o, x, y, exp_dz);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            check({tag, ".busy_after_accept"}, busy, 1'b1);
            n = 0; busy_cnt = 0;
            while (!done && n < 40) begin
                if (busy) busy_cnt++;
                @(posedge clk); #1;
                n++;
            end
            check({tag, ".latency"}, n, 33);
            check({tag, ".busy_cycles"}, busy_cnt, 33);
            check({tag, ".busy_at_done"}, busy, 1'b0);
            check({tag, ".div_zero"}, div_zero, exp_dz);
            check({tag, ".hi"}, hi, model_hi);
            check({tag, ".lo"}, lo, model_lo);
        end else if (o <= 3'd5) begin
            check({tag, ".done"}, done, 1'b1);
            check({tag, ".busy"}, busy, 1'b0);
            check({tag, ".hi"}, hi, model_hi);
            check({tag, ".lo"}, lo, model_lo);
        end else begin
            check({tag, ".done"}, done, 1'b0);
            check({tag, ".busy"}, busy, 1'b0);
            check({tag, ".hi"}, hi, old_hi);
            check({tag, ".lo"}, lo, old_lo);
        end
    endtask

    initial begin
        int n, dcount, first_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset.busy", busy, 1'b0);
        check("post_reset.done", done, 1'b0);
        check("post_reset.div_zero", div_zero, 1'b0);

        do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max.hi_const", hi, 32'hFFFFFFFE);
        check("multu_max.lo_const", lo, 32'h00000001);
        @(posedge clk); #1;
        check("multu_max.done_one_cycle", done, 1'b0);
        do_op("mult_mixed", 3'd0, 32'hFFFFFFFD, 32'd5);
        check("mult_mixed.lo_const", lo, 32'hFFFFFFF1);
        do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        check("div_neg.lo_const", lo, 32'hFFFFFFFD);
        do_op("divu", 3'd3, 32'd100, 32'd7);
        do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf.lo_const", lo, 32'h80000000);
        do_op("mthi", 3'd4, 32'h1234, 32'd0);
        @(posedge clk); #1;
        check("mthi.done_one_cycle", done, 1'b0);
        do_op("mtlo", 3'd5, 32'h5678, 32'd0);
        do_op("divu_zero", 3'd3, 32'd9, 32'd0);
        check("divu_zero.hi_kept", hi, 32'h1234);
        check("divu_zero.lo_kept", lo, 32'h5678);
        do_op("div_zero_signed", 3'd2, 32'hFFFFFF00, 32'd0);
        do_op("reserved6", 3'd6, 32'hDEAD, 32'hBEEF);
        do_op("reserved7", 3'd7, 32'hDEAD, 32'hBEEF);

        // A start arriving mid-operation must be dropped, not queued.
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        model_lo = 32'd14; model_hi = 32'd2;
        n = 0; dcount = 0; first_done = 0;
        while (n < 45) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) begin start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3; end
            else start = 1'b0;
            if (done) begin
                dcount++;
                if (first_done == 0) first_done = n;
            end
        end
        check("midop.done_count", dcount, 1);
        check("midop.done_cycle", first_done, 34);
        check("midop.hi", hi, model_hi);
        check("midop.lo", lo, model_lo);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'($urandom_range(0, 1000))};
            do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        // Asynchronous reset in the middle of a multiply aborts it.
        do_op("mthi_pre", 3'd4, 32'hAAAA5555, 32'd0);
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_hi = 32'd0; model_lo = 32'd0;
        check("abort.hi", hi, model_hi);
        check("abort.lo", lo, model_lo);
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort.no_done", dcount, 0);
        check("abort.hi_after", hi, model_hi);
        do_op("after_abort", 3'd1, 32'd6, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
